// File: rtl/vga_line_pattern_gen.sv
// Sloped line/band pattern generator with a 2-stage colour pipeline and matched sync delay.
// Optional LINE_PATTERN_SCROLL_EN: offsets advance by one pixel per frame between loads.
module vga_line_pattern_gen #(
   parameter int unsigned H_W       = 12,
   parameter int unsigned V_W       = 12,
   parameter int unsigned N_LINES   = 4,
   parameter int unsigned SLOPE_W   = 3,
   parameter int unsigned OFF_W     = 6,
   parameter int unsigned BAND_HALF = 50,
   parameter int unsigned COLOR_W   = 4
) (
   input  logic                    clk_in,
   input  logic                    reset,
   input  logic [H_W-1:0]          h_count,
   input  logic [V_W-1:0]          v_count,
   input  logic                    display_en_in,
   input  logic                    h_sync_in,
   input  logic                    v_sync_in,
   input  logic                    update_req,
   input  logic [16*N_LINES-1:0]   rnd_in,
   input  logic [3*COLOR_W-1:0]    fg_rgb_in,
   input  logic [3*COLOR_W-1:0]    bg_rgb_in,
   output logic [COLOR_W-1:0]      r_out,
   output logic [COLOR_W-1:0]      g_out,
   output logic [COLOR_W-1:0]      b_out,
   output logic                    h_sync,
   output logic                    v_sync,
   output logic                    update_pending,
   output logic [7:0]              frame_count
);

   localparam int unsigned BASE_W = V_W + SLOPE_W + 1;
   localparam int unsigned CMP_W  = ((BASE_W > H_W) ? BASE_W : H_W) + 1;
   localparam int unsigned RGB_W  = 3 * COLOR_W;

   logic [SLOPE_W-1:0] slope_q  [N_LINES];
   logic [SLOPE_W-1:0] slope_d  [N_LINES];
   logic [OFF_W-1:0]   offset_q [N_LINES];
   logic [OFF_W-1:0]   offset_d [N_LINES];
   logic [BASE_W-1:0]  base_q   [N_LINES];
   logic [BASE_W-1:0]  base_d   [N_LINES];
   logic [N_LINES-1:0] mode_q, mode_d;
   logic [RGB_W-1:0]   fg_q, fg_d, bg_q, bg_d, rgb_q, rgb_d;
   logic [H_W-1:0]     h1_q, h1_d;
   logic               de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
   logic               hs_q, hs_d, vs_q, vs_d;
   logic               pending_q, pending_d;
   logic [7:0]         frame_count_q, frame_count_d;
   logic               frame_start, load;
   logic [N_LINES-1:0] hit_vec;
   logic [CMP_W-1:0]   h_ext, base_ext;
   logic               unused_rnd;

   // Shadow update and stage 1 share one block: stage 1 sees the *_d values so a
   // frame-start load already applies to pixel (0,0).
   always_comb begin
      frame_start   = (h_count == '0) && (v_count == '0);
      load          = frame_start && (pending_q || update_req);
      pending_d     = load ? 1'b0 : (update_req ? 1'b1 : pending_q);
      frame_count_d = frame_start ? frame_count_q + 8'd1 : frame_count_q;
      fg_d          = load ? fg_rgb_in : fg_q;
      bg_d          = load ? bg_rgb_in : bg_q;
      mode_d        = mode_q;
      unused_rnd    = ^rnd_in;
      for (int unsigned k = 0; k < N_LINES; k++) begin
         slope_d[k]  = slope_q[k];
         offset_d[k] = offset_q[k];
         if (load) begin
            slope_d[k]  = rnd_in[16*k +: SLOPE_W];
            offset_d[k] = rnd_in[16*k+SLOPE_W +: OFF_W];
            mode_d[k]   = rnd_in[16*k+15];
         end
`ifdef LINE_PATTERN_SCROLL_EN
         else if (frame_start) begin
            offset_d[k] = offset_q[k] + 1'b1;
         end
`endif
         base_d[k] = BASE_W'(slope_d[k]) * BASE_W'(v_count) + BASE_W'(offset_d[k]);
      end
      h1_d  = h_count;
      de1_d = display_en_in;
      hs1_d = h_sync_in;
      vs1_d = v_sync_in;
   end

   // Band lower bound is skipped when base < BAND_HALF so it never wraps negative.
   always_comb begin
      hit_vec  = '0;
      h_ext    = CMP_W'(h1_q);
      base_ext = '0;
      for (int unsigned k = 0; k < N_LINES; k++) begin
         base_ext = CMP_W'(base_q[k]);
         if (mode_q[k]) begin
            hit_vec[k] = ((base_ext < CMP_W'(BAND_HALF)) ||
                          (h_ext > base_ext - CMP_W'(BAND_HALF))) &&
                         (h_ext < base_ext + CMP_W'(BAND_HALF));
         end else begin
            hit_vec[k] = (h_ext == base_ext);
         end
      end
      rgb_d = !de1_q ? '0 : ((|hit_vec) ? fg_q : bg_q);
      hs_d  = hs1_q;
      vs_d  = vs1_q;
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         for (int unsigned k = 0; k < N_LINES; k++) begin
            slope_q[k]  <= '0;
            offset_q[k] <= '0;
            base_q[k]   <= '0;
         end
         mode_q        <= '0;
         fg_q          <= '0;
         bg_q          <= '0;
         rgb_q         <= '0;
         h1_q          <= '0;
         de1_q         <= 1'b0;
         hs1_q         <= 1'b0;
         vs1_q         <= 1'b0;
         hs_q          <= 1'b0;
         vs_q          <= 1'b0;
         pending_q     <= 1'b0;
         frame_count_q <= '0;
      end else begin
         for (int unsigned k = 0; k < N_LINES; k++) begin
            slope_q[k]  <= slope_d[k];
            offset_q[k] <= offset_d[k];
            base_q[k]   <= base_d[k];
         end
         mode_q        <= mode_d;
         fg_q          <= fg_d;
         bg_q          <= bg_d;
         rgb_q         <= rgb_d;
         h1_q          <= h1_d;
         de1_q         <= de1_d;
         hs1_q         <= hs1_d;
         vs1_q         <= vs1_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         pending_q     <= pending_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign r_out          = rgb_q[RGB_W-1 -: COLOR_W];
   assign g_out          = rgb_q[2*COLOR_W-1 -: COLOR_W];
   assign b_out          = rgb_q[COLOR_W-1:0];
   assign h_sync         = hs_q;
   assign v_sync         = vs_q;
   assign update_pending = pending_q;
   assign frame_count    = frame_count_q;

endmodule

// File: doc/vga_line_pattern_gen.md
# vga_line_pattern_gen

Parametrised pixel-pattern generator between `vga_sync` and the VGA pins. It draws `N_LINES` sloped lines or bands, each given as `h = slope*v_count + offset`, over a background. Per-line parameters come from random words supplied by the LFSR. They are double-buffered so a pattern only changes at a frame boundary. The colour path is a 2-stage pipeline, and the syncs are delayed to match it.

## Interface
Parameters:
- `H_W`, 12, width of `h_count`
- `V_W`, 12, width of `v_count`
- `N_LINES`, 4, number of line channels (1..8)
- `SLOPE_W`, 3, slope field width
- `OFF_W`, 6, offset field width; `SLOPE_W+OFF_W` ≤ 15
- `BAND_HALF`, 50, half-width of a band in pixels
- `COLOR_W`, 4, bits per colour component

Ports:
- `clk_in`  in  1  pixel clock
- `reset`  in  1  asynchronous, active-low reset
- `h_count`  in  `H_W`  horizontal position from `vga_sync`
- `v_count`  in  `V_W`  vertical position from `vga_sync`
- `display_en_in`  in  1  active-pixel flag from `vga_sync`
- `h_sync_in`, `v_sync_in`  in  1 each  raw syncs from `vga_sync`
- `update_req`  in  1  one-cycle pulse (tempo) requesting a new pattern
- `rnd_in`  in  `16*N_LINES`  channel k word = `rnd_in[16k+15:16k]`
- `fg_rgb_in`, `bg_rgb_in`  in  `3*COLOR_W` each  {r,g,b} colours to load
- `r_out`, `g_out`, `b_out`  out  `COLOR_W`  registered colour
- `h_sync`, `v_sync`  out  1  syncs delayed to align with colour
- `update_pending`  out  1  request accepted, not yet applied
- `frame_count`  out  8  count of frame starts, wraps at 255

## Operation
- **Word layout per channel:** `slope = w[SLOPE_W-1:0]`, `offset = w[SLOPE_W+OFF_W-1:SLOPE_W]`, `mode = w[15]` (0 = line, 1 = band).
- **Frame start:** the cycle with `h_count==0 && v_count==0` at the input.
- **Request:** `update_req` sets `update_pending`.
- **Load:** at frame start with `update_pending` set, or with `update_req` high in the same cycle, the shadow registers load from `rnd_in`, `fg_rgb_in` and `bg_rgb_in`. `update_pending` clears. The inputs sampled that cycle are used.
- **Between loads:** `rnd_in` and the colour inputs are ignored.
- **`frame_count`:** increments at every frame start.
- **Stage 1:** `base_k = slope_k*v_count + offset_k`, computed unsigned at `V_W+SLOPE_W+1` bits with no wrap.
- **Stage 1 delays:** `h_count`, `display_en_in` and the syncs are delayed 1 cycle.
- **Stage 2, line hit:** `h == base_k`.
- **Stage 2, band hit:** `h > base_k - BAND_HALF && h < base_k + BAND_HALF`. If `base_k < BAND_HALF`, the lower bound is treated as satisfied (no negative wrap).
- **Pixel:** any channel hit gives fg; no hit gives bg. If delayed `display_en` is 0, the output is 0.
- **Reset mid-frame:** clears everything immediately. The shadow registers revert to reset values until the next load.

## Timing
- Latency from `h_count`/`display_en_in`/`*_sync_in` to `r/g/b_out` and `h_sync`/`v_sync` is exactly 2 cycles. Syncs stay in phase with colour.
- A load at the frame-start cycle affects colour from that frame's pixel (0,0) onward, i.e. output 2 cycles later.
- `update_pending` rises 1 cycle after `update_req` and falls 1 cycle after the load cycle.
- A new `update_req` while pending is absorbed; no second load occurs.
- Reset values:
  - `r_out`, `g_out`, `b_out` = 0
  - `h_sync`, `v_sync` = 0
  - `update_pending` = 0
  - `frame_count` = 0
  - all pipeline registers 0
  - shadow slope, offset and mode = 0
  - fg and bg = 0

## Configuration
- `LINE_PATTERN_SCROLL_EN` defined: at each frame start without a load, every `offset_k` increments by 1, modulo 2^`OFF_W`, so lines drift right one pixel per frame. A load overrides the increment.
- Not defined: offsets are constant between loads.

## Test plan
- **Reset/latency:** hold `reset`=0 → all outputs 0. Release, drive `display_en_in`=1 and toggle `h_sync_in` → `h_sync` follows 2 cycles later; colour 0 until the first load.
- **Line mode:** `N_LINES`=1, word slope=2, offset=5, mode=0, fg=FFF, bg=000, pulse `update_req` before a frame.
  - On `v_count`=10, only `h_count`=25 gives 0xF on r/g/b.
- **Band clamp:** slope=0, offset=10, mode=1, `BAND_HALF`=50.
  - `h_count` 0..59 → fg.
  - `h_count` 60 → bg.
- **Deferred update:** pulse `update_req` mid-frame with new words → `update_pending`=1 and the old pattern persists. New pattern from the next frame; `frame_count` +1.
- **Priority/overlap:** two channels both hit the same pixel → a single fg output. `display_en_in`=0 on a hit pixel → 0.
- **Scroll macro:** with `LINE_PATTERN_SCROLL_EN`, offset=63, `OFF_W`=6 → next frame offset 0, line moves from h=63 to h=0 (slope 0). Without the macro, the line stays at 63.
